// File: rtl/banco_registros_param.sv
`default_nettype none
// ============================================================================
// Module  : banco_registros_param
// Brief   : Parametrised register bank, 2 registered read ports, 1 write port,
//           per-register pending (scoreboard) bit, optional zero register/bypass.
// Revision: 1.0 - initial release
// ============================================================================
module banco_registros_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_pend_1,
    output logic              rd_pend_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              res_en,
    input  logic [ADDR_W-1:0] res_addr,
    output logic              pend_any
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [DEPTH-1:0]  pend_src;

    logic              wr_ok;
    logic              res_ok;
    logic              rd_zero_1;
    logic              rd_zero_2;
    logic [DATA_W-1:0] rd_data_1_d;
    logic [DATA_W-1:0] rd_data_2_d;
    logic              rd_pend_1_d;
    logic              rd_pend_2_d;
    logic              pend_any_d;

    // Register 0 swallows writes and reservations when hardwired to zero.
    assign wr_ok     = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign res_ok    = res_en && !((ZERO_REG != 0) && (res_addr == '0));
    assign rd_zero_1 = (ZERO_REG != 0) && (rd_addr_1 == '0);
    assign rd_zero_2 = (ZERO_REG != 0) && (rd_addr_2 == '0);

    // Reservation is applied after the write so the new producer keeps the bit set.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok)
            pend_d[wr_addr] = 1'b0;
        if (res_ok)
            pend_d[res_addr] = 1'b1;
    end

    assign pend_src = (BYPASS != 0) ? pend_d : pend_q;

    always_comb begin
        rd_data_1_d = regs_q[rd_addr_1];
        rd_data_2_d = regs_q[rd_addr_2];
        if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr_1))
            rd_data_1_d = wr_data;
        if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr_2))
            rd_data_2_d = wr_data;
        if (rd_zero_1)
            rd_data_1_d = '0;
        if (rd_zero_2)
            rd_data_2_d = '0;
    end

    assign rd_pend_1_d = pend_src[rd_addr_1] && !rd_zero_1;
    assign rd_pend_2_d = pend_src[rd_addr_2] && !rd_zero_2;
    assign pend_any_d  = |pend_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            pend_q <= '0;
        end else begin
            if (wr_ok)
                regs_q[wr_addr] <= wr_data;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_1 <= '0;
            rd_data_2 <= '0;
            rd_pend_1 <= 1'b0;
            rd_pend_2 <= 1'b0;
            pend_any  <= 1'b0;
        end else begin
            rd_data_1 <= rd_data_1_d;
            rd_data_2 <= rd_data_2_d;
            rd_pend_1 <= rd_pend_1_d;
            rd_pend_2 <= rd_pend_2_d;
            pend_any  <= pend_any_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_banco_registros_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_banco_registros_param
// Brief   : Directed self-checking bench over four parameterisations of the bank.
// Revision: 1.0 - initial release
// ============================================================================
module tb_banco_registros_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rd_addr_1 = '0, rd_addr_2 = '0, wr_addr = '0, res_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_en = 1'b0, res_en = 1'b0;

    // Default (ZERO_REG=1, BYPASS=1)
    logic [31:0] a_d1, a_d2;
    logic        a_p1, a_p2, a_pa;
    // BYPASS=0
    logic [31:0] b_d1, b_d2;
    logic        b_p1, b_p2, b_pa;
    // ZERO_REG=0
    logic [31:0] z_d1, z_d2;
    logic        z_p1, z_p2, z_pa;
    // DATA_W=16, ADDR_W=3
    logic [2:0]  s_ra1 = '0, s_ra2 = '0, s_wa = '0, s_resa = '0;
    logic [15:0] s_wd = '0;
    logic        s_we = 1'b0, s_rese = 1'b0;
    logic [15:0] s_d1, s_d2;
    logic        s_p1, s_p2, s_pa;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    banco_registros_param u_dut (
        .clk(clk), .rst(rst), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(a_d1), .rd_data_2(a_d2), .rd_pend_1(a_p1), .rd_pend_2(a_p2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .res_en(res_en), .res_addr(res_addr), .pend_any(a_pa)
    );

    banco_registros_param #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(b_d1), .rd_data_2(b_d2), .rd_pend_1(b_p1), .rd_pend_2(b_p2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .res_en(res_en), .res_addr(res_addr), .pend_any(b_pa)
    );

    banco_registros_param #(.ZERO_REG(0)) u_nz (
        .clk(clk), .rst(rst), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(z_d1), .rd_data_2(z_d2), .rd_pend_1(z_p1), .rd_pend_2(z_p2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .res_en(res_en), .res_addr(res_addr), .pend_any(z_pa)
    );

    banco_registros_param #(.DATA_W(16), .ADDR_W(3)) u_small (
        .clk(clk), .rst(rst), .rd_addr_1(s_ra1), .rd_addr_2(s_ra2),
        .rd_data_1(s_d1), .rd_data_2(s_d2), .rd_pend_1(s_p1), .rd_pend_2(s_p2),
        .wr_en(s_we), .wr_addr(s_wa), .wr_data(s_wd),
        .res_en(s_rese), .res_addr(s_resa), .pend_any(s_pa)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;

        // Reset: load reg 5 and reserve reg 9, then reset mid-cycle
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        res_en = 1'b1; res_addr = 5'd9;
        rd_addr_1 = 5'd5; rd_addr_2 = 5'd9;
        tick();
        wr_en = 1'b0; res_en = 1'b0;
        check("pre_rst_data1", a_d1, 32'hDEADBEEF);
        check("pre_rst_pend2", {31'b0, a_p2}, 32'h1);
        check("pre_rst_pany",  {31'b0, a_pa}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_data1", a_d1, 32'h0);
        check("rst_data2", a_d2, 32'h0);
        check("rst_pend1", {31'b0, a_p1}, 32'h0);
        check("rst_pend2", {31'b0, a_p2}, 32'h0);
        check("rst_pany",  {31'b0, a_pa}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_reg5", a_d1, 32'h0);
        check("post_rst_pend9", {31'b0, a_p2}, 32'h0);

        // Write/read visibility with and without bypass
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; rd_addr_1 = 5'd7;
        tick();
        wr_en = 1'b0;
        check("byp_same_edge",   a_d1, 32'h12345678);
        check("nobyp_same_edge", b_d1, 32'h0);
        tick();
        check("nobyp_next_edge", b_d1, 32'h12345678);

        // Zero register
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        res_en = 1'b1; res_addr = 5'd0; rd_addr_1 = 5'd0;
        tick();
        wr_en = 1'b0; res_en = 1'b0;
        check("zero_data1", a_d1, 32'h0);
        check("zero_pend1", {31'b0, a_p1}, 32'h0);
        check("nozero_data1", z_d1, 32'hFFFFFFFF);
        check("nozero_pend1", {31'b0, z_p1}, 32'h1);
        tick();
        check("zero_data1_later", a_d1, 32'h0);
        check("zero_pany", {31'b0, a_pa}, 32'h0);

        // Scoreboard on reg 3
        res_en = 1'b1; res_addr = 5'd3; rd_addr_2 = 5'd3;
        tick();
        res_en = 1'b0;
        check("res_pend2", {31'b0, a_p2}, 32'h1);
        check("res_pany",  {31'b0, a_pa}, 32'h1);
        check("nobyp_res_pend2", {31'b0, b_p2}, 32'h0);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h000000A5;
        tick();
        wr_en = 1'b0;
        check("wr_clr_pend2", {31'b0, a_p2}, 32'h0);
        check("wr_clr_pany",  {31'b0, a_pa}, 32'h0);
        check("wr_data2",     a_d2, 32'h000000A5);
        check("nobyp_wr_pend2", {31'b0, b_p2}, 32'h1);
        wr_en = 1'b1; res_en = 1'b1; wr_addr = 5'd3; res_addr = 5'd3;
        wr_data = 32'h000000A5;
        tick();
        wr_en = 1'b0; res_en = 1'b0;
        check("both_data2", a_d2, 32'h000000A5);
        check("both_pend2", {31'b0, a_p2}, 32'h1);
        check("both_pany",  {31'b0, a_pa}, 32'h1);
        tick();
        check("both_pend2_hold", {31'b0, a_p2}, 32'h1);

        // Dual-port sweep on the 16x8 bank
        s_we = 1'b1;
        for (int i = 1; i < 8; i++) begin
            s_wa = 3'(i);
            s_wd = 16'(i * 16'h1111);
            tick();
        end
        s_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_ra1 = 3'(i);
            s_ra2 = 3'(7 - i);
            tick();
            check($sformatf("sweep_p1_%0d", i), {16'b0, s_d1}, 32'(i * 32'h1111));
            check($sformatf("sweep_p2_%0d", i), {16'b0, s_d2}, 32'((7 - i) * 32'h1111));
        end
        check("sweep_pany", {31'b0, s_pa}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/banco_registros_param.md
# banco_registros_param

Parametrised register bank for the pipelined datapath, successor to the fixed 32x32 bank. It provides width and depth parameters, two registered read ports, one write port, an optional hardwired zero register, and selectable write-to-read bypass. It also keeps a per-register pending (scoreboard) bit so decode can detect load-use hazards. It sits in the decode stage: writeback drives the write port, and decode drives the reservation port.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes/reservations
- BYPASS, 1, when 1 a read at the same edge as a write/reservation returns post-update contents

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rd_addr_1  input  ADDR_W  read port 1 address
- rd_addr_2  input  ADDR_W  read port 2 address
- rd_data_1  output  DATA_W  registered read data, port 1
- rd_data_2  output  DATA_W  registered read data, port 2
- rd_pend_1  output  1  registered pending flag of rd_addr_1
- rd_pend_2  output  1  registered pending flag of rd_addr_2
- wr_en  input  1  write enable
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- res_en  input  1  reservation enable, marks a register as awaiting a result
- res_addr  input  ADDR_W  register being reserved
- pend_any  output  1  registered OR of all pending bits

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits, plus one pending bit per register.
- Write: wr_en=1 at an edge stores wr_data in reg[wr_addr] and clears pend[wr_addr].
- Reservation: res_en=1 at an edge sets pend[res_addr].
- Same edge, res_addr == wr_addr, both enabled: data is written and pend stays set. The new producer wins.
- ZERO_REG=1 and address 0:
  - writes and reservations are dropped;
  - reads return 0 with pend 0.
- Read, every edge: rd_data_n and rd_pend_n load the contents of rd_addr_n.
  - BYPASS=1: uses post-update values, i.e. includes a same-edge write/reservation.
  - BYPASS=0: uses pre-edge values.
- Both read ports may address the same register, or the write address, without restriction.
- pend_any: registered OR of all pending bits after the edge's update. It follows the same BYPASS rule as the read ports.
- No state machine beyond the storage and pending arrays. All outputs are registered.

## Timing
- Reset: rst high immediately clears all registers, all pending bits, rd_data_1/2, rd_pend_1/2 and pend_any to 0, independent of clk.
- Reset deassertion: the first rising edge with rst low performs normal operation.
- Read latency: 1 cycle. Address presented before edge k gives data valid after edge k.
- Write visibility:
  - BYPASS=1: a read issued at the same edge k shows the write.
  - BYPASS=0: the write is visible to a read issued at edge k+1.
- Pending: a reservation at edge k shows on rd_pend after edge k (BYPASS=1) or after edge k+1 (BYPASS=0).
- Reset mid-operation: any write or reservation coinciding with rst high is lost.

## Test plan
- Reset: write 0xDEADBEEF to reg 5, assert rst asynchronously mid-cycle -> rd_data_1/2, rd_pend_1/2 and pend_any are 0 immediately. After release, reading reg 5 returns 0.
- Write/read, BYPASS=1: wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr_1=7 on the same edge -> rd_data_1=0x12345678 after that edge.
- Same stimulus with BYPASS=0 -> rd_data_1 is the old value (0) after that edge, and 0x12345678 one edge later.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to reg 0 and reserve reg 0 -> rd_data_1=0 and rd_pend_1=0. With ZERO_REG=0 the same stimulus gives 0xFFFFFFFF.
- Scoreboard: reserve reg 3 -> rd_pend_2=1 and pend_any=1. Write reg 3 with 0xA5 -> rd_pend_2=0 and pend_any=0. Reserve and write reg 3 on the same edge -> data 0xA5 stored, rd_pend_2=1.
- Dual-port sweep with DATA_W=16, ADDR_W=3: write i*0x1111 to regs 1..7, then read pairs (i, 7-i) -> both ports return the written values in the same cycle.
